// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// multiply/divide start codes and the md_timer state type.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] MD_NOP  = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    // One-hot so MdBusy/MdDone come straight off a state flop.
    typedef logic [2:0] md_state_t;
    localparam md_state_t MD_IDLE = 3'b001;
    localparam md_state_t MD_RUN  = 3'b010;
    localparam md_state_t MD_DONE = 3'b100;
    localparam int MD_RUN_BIT  = 1;
    localparam int MD_DONE_BIT = 2;

    // A later stage writes a non-zero register that matches the source.
    function automatic logic stage_hit(input logic       reg_write,
                                       input logic [4:0] write_reg,
                                       input logic [4:0] src_reg);
        return reg_write && (write_reg != 5'd0) && (write_reg == src_reg);
    endfunction

endpackage

// File: rtl/md_timer.sv
// Multiply/divide latency tracker: IDLE -> RUN for N cycles -> DONE for one
// cycle. The current state is exported for the top and for debug.
module md_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] md_start,
    output md_state_t  md_state
);

    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

    md_state_t  state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE, MD_DONE: begin
                state_d = MD_IDLE;
                if (md_start == MD_MULT) begin
                    cnt_d   = MULT_LOAD;
                    state_d = MD_RUN;
                end else if (md_start == MD_DIV) begin
                    cnt_d   = DIV_LOAD;
                    state_d = MD_RUN;
                end
            end
            // Starts arriving here are dropped; the count only runs down.
            MD_RUN: begin
                if (cnt_q == 6'd0) begin
                    state_d = MD_DONE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_state = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: EX/ID forwarding selects, load-use, branch and
// multiply/divide stalls, plus the multiply/divide busy/done tracker.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs_D,
    input  logic [4:0] Rt_D,
    input  logic [4:0] Rs_E,
    input  logic [4:0] Rt_E,
    input  logic [4:0] WriteReg_E,
    input  logic [4:0] WriteReg_M,
    input  logic [4:0] WriteReg_W,
    input  logic       RegWrite_E,
    input  logic       RegWrite_M,
    input  logic       RegWrite_W,
    input  logic       MemToReg_E,
    input  logic       MemToReg_M,
    input  logic       Branch_D,
    input  logic       MdUse_D,
    input  logic [1:0] MdStart_E,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic [1:0] ForwardA_E,
    output logic [1:0] ForwardB_E,
    output logic       ForwardA_D,
    output logic       ForwardB_D,
    output logic       MdBusy,
    output logic       MdDone
);

    md_state_t md_state;
    logic      lu, br, md, stall;

    md_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .md_start(MdStart_E),
        .md_state(md_state)
    );

    assign MdBusy = md_state[MD_RUN_BIT];
    assign MdDone = md_state[MD_DONE_BIT];

    assign lu = stage_hit(MemToReg_E, WriteReg_E, Rs_D) ||
                stage_hit(MemToReg_E, WriteReg_E, Rt_D);

    // A branch resolves in ID, so an ALU result still in EX or a load in MEM
    // cannot be forwarded in time.
    assign br = Branch_D &&
                (stage_hit(RegWrite_E, WriteReg_E, Rs_D) ||
                 stage_hit(RegWrite_E, WriteReg_E, Rt_D) ||
                 stage_hit(MemToReg_M, WriteReg_M, Rs_D) ||
                 stage_hit(MemToReg_M, WriteReg_M, Rt_D));

    assign md    = MdUse_D && MdBusy;
    assign stall = rst_n && (lu || br || md);

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

    always_comb begin
        ForwardA_E = FWD_RF;
        ForwardB_E = FWD_RF;
        ForwardA_D = 1'b0;
        ForwardB_D = 1'b0;
        if (rst_n) begin
            if (stage_hit(RegWrite_M, WriteReg_M, Rs_E))      ForwardA_E = FWD_MEM;
            else if (stage_hit(RegWrite_W, WriteReg_W, Rs_E)) ForwardA_E = FWD_WB;
            if (stage_hit(RegWrite_M, WriteReg_M, Rt_E))      ForwardB_E = FWD_MEM;
            else if (stage_hit(RegWrite_W, WriteReg_W, Rt_E)) ForwardB_E = FWD_WB;
            ForwardA_D = stage_hit(RegWrite_M, WriteReg_M, Rs_D);
            ForwardB_D = stage_hit(RegWrite_M, WriteReg_M, Rt_D);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, stalls and the md_timer sequence.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E;
    logic [4:0] WriteReg_E, WriteReg_M, WriteReg_W;
    logic       RegWrite_E, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M;
    logic       Branch_D, MdUse_D;
    logic [1:0] MdStart_E;
    logic       StallF, StallD, FlushE;
    logic [1:0] ForwardA_E, ForwardB_E;
    logic       ForwardA_D, ForwardB_D;
    logic       MdBusy, MdDone;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
        .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemToReg_E(MemToReg_E), .MemToReg_M(MemToReg_M),
        .Branch_D(Branch_D), .MdUse_D(MdUse_D), .MdStart_E(MdStart_E),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
        .MdBusy(MdBusy), .MdDone(MdDone)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs_D = 0; Rt_D = 0; Rs_E = 0; Rt_E = 0;
        WriteReg_E = 0; WriteReg_M = 0; WriteReg_W = 0;
        RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
        MemToReg_E = 0; MemToReg_M = 0;
        Branch_D = 0; MdUse_D = 0; MdStart_E = 2'b00;
    endtask

    // Counts cycles with MdBusy high (bounded); optionally drives one start
    // code at a given RUN cycle to show it is ignored.
    task automatic run_length(input int inject_at, input logic [1:0] code, output int n);
        n = 0;
        while (MdBusy === 1'b1 && n < 100) begin
            if (n == inject_at) MdStart_E = code;
            tick();
            MdStart_E = 2'b00;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        RegWrite_M = 1; WriteReg_M = 8; Rs_E = 8; Rt_E = 8; Rs_D = 8; Rt_D = 8;
        MemToReg_E = 1; WriteReg_E = 8; Branch_D = 1; RegWrite_E = 1;
        tick(); tick();
        n_cmp++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            n_err++; $display("FAIL reset_stall: got %b expected 000", {StallF, StallD, FlushE});
        end
        n_cmp++;
        if ({ForwardA_E, ForwardB_E, ForwardA_D, ForwardB_D} !== 6'b0) begin
            n_err++; $display("FAIL reset_fwd: got %b expected 000000",
                              {ForwardA_E, ForwardB_E, ForwardA_D, ForwardB_D});
        end
        n_cmp++;
        if ({MdBusy, MdDone} !== 2'b00) begin
            n_err++; $display("FAIL reset_md: got %b expected 00", {MdBusy, MdDone});
        end
        clear_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        MemToReg_E = 1; WriteReg_E = 5; Rs_D = 5; Rt_D = 3;
        #1;
        n_cmp++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            n_err++; $display("FAIL load_use_rs: got %b expected 111", {StallF, StallD, FlushE});
        end
        tick();
        MemToReg_E = 0; WriteReg_E = 0;
        #1;
        n_cmp++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            n_err++; $display("FAIL load_use_clear: got %b expected 000", {StallF, StallD, FlushE});
        end
        MemToReg_E = 1; WriteReg_E = 3;
        #1;
        n_cmp++;
        if (StallF !== 1'b1) begin
            n_err++; $display("FAIL load_use_rt: got %b expected 1", StallF);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        RegWrite_M = 1; WriteReg_M = 8; RegWrite_W = 1; WriteReg_W = 8; Rs_E = 8;
        #1;
        n_cmp++;
        if (ForwardA_E !== 2'b10) begin
            n_err++; $display("FAIL fwd_a_mem: got %b expected 10", ForwardA_E);
        end
        WriteReg_M = 0;
        #1;
        n_cmp++;
        if (ForwardA_E !== 2'b01) begin
            n_err++; $display("FAIL fwd_a_wb: got %b expected 01", ForwardA_E);
        end
        RegWrite_W = 0;
        #1;
        n_cmp++;
        if (ForwardA_E !== 2'b00) begin
            n_err++; $display("FAIL fwd_a_rf: got %b expected 00", ForwardA_E);
        end
        RegWrite_M = 1; WriteReg_M = 12; RegWrite_W = 1; WriteReg_W = 13;
        Rs_E = 13; Rt_E = 12; Rs_D = 12; Rt_D = 13;
        #1;
        n_cmp++;
        if ({ForwardA_E, ForwardB_E} !== 4'b0110) begin
            n_err++; $display("FAIL fwd_ab_mix: got %b expected 0110", {ForwardA_E, ForwardB_E});
        end
        n_cmp++;
        if ({ForwardA_D, ForwardB_D} !== 2'b10) begin
            n_err++; $display("FAIL fwd_d: got %b expected 10", {ForwardA_D, ForwardB_D});
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_zero_reg();
        clear_inputs();
        RegWrite_M = 1; WriteReg_M = 0; Rs_E = 0; Rs_D = 0;
        RegWrite_W = 1; WriteReg_W = 0;
        MemToReg_E = 1; WriteReg_E = 0;
        #1;
        n_cmp++;
        if (ForwardA_E !== 2'b00) begin
            n_err++; $display("FAIL zero_fwd: got %b expected 00", ForwardA_E);
        end
        n_cmp++;
        if ({StallF, StallD, FlushE, ForwardA_D} !== 4'b0000) begin
            n_err++; $display("FAIL zero_stall: got %b expected 0000", {StallF, StallD, FlushE, ForwardA_D});
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        RegWrite_E = 1; WriteReg_E = 7; Rt_D = 7;
        #1;
        n_cmp++;
        if (StallF !== 1'b0) begin
            n_err++; $display("FAIL br_no_branch: got %b expected 0", StallF);
        end
        Branch_D = 1;
        #1;
        n_cmp++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            n_err++; $display("FAIL br_ex: got %b expected 111", {StallF, StallD, FlushE});
        end
        RegWrite_E = 0; MemToReg_M = 1; WriteReg_M = 9; Rs_D = 9;
        #1;
        n_cmp++;
        if (StallD !== 1'b1) begin
            n_err++; $display("FAIL br_mem_load: got %b expected 1", StallD);
        end
        MemToReg_M = 0; RegWrite_M = 1;
        #1;
        n_cmp++;
        if ({StallD, ForwardA_D} !== 2'b01) begin
            n_err++; $display("FAIL br_mem_alu: got %b expected 01", {StallD, ForwardA_D});
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_divide();
        int n;
        int bad;
        clear_inputs();
        MdUse_D = 1;
        MdStart_E = 2'b10;
        #1;
        n_cmp++;
        if (StallF !== 1'b0) begin
            n_err++; $display("FAIL div_pre_stall: got %b expected 0", StallF);
        end
        tick();
        MdStart_E = 2'b00;
        n = 0; bad = 0;
        while (MdBusy === 1'b1 && n < 100) begin
            if ({StallF, MdDone} !== 2'b10) bad++;
            tick();
            n++;
        end
        n_cmp++;
        if (n != 32) begin
            n_err++; $display("FAIL div_busy_len: got %0d expected 32", n);
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL div_stall_during_run: got %0d bad cycles expected 0", bad);
        end
        n_cmp++;
        if ({MdDone, StallF} !== 2'b10) begin
            n_err++; $display("FAIL div_done: got %b expected 10", {MdDone, StallF});
        end
        tick();
        n_cmp++;
        if ({MdBusy, MdDone} !== 2'b00) begin
            n_err++; $display("FAIL div_idle: got %b expected 00", {MdBusy, MdDone});
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int n;
        clear_inputs();
        MdStart_E = 2'b01;
        tick();
        MdStart_E = 2'b00;
        run_length(1, 2'b10, n);
        n_cmp++;
        if (n != 4) begin
            n_err++; $display("FAIL mult_ignore_start_len: got %0d expected 4", n);
        end
        n_cmp++;
        if (MdDone !== 1'b1) begin
            n_err++; $display("FAIL mult_done: got %b expected 1", MdDone);
        end
        MdStart_E = 2'b01;
        tick();
        MdStart_E = 2'b00;
        n_cmp++;
        if ({MdBusy, MdDone} !== 2'b10) begin
            n_err++; $display("FAIL b2b_no_gap: got %b expected 10", {MdBusy, MdDone});
        end
        run_length(-1, 2'b00, n);
        n_cmp++;
        if (n != 4) begin
            n_err++; $display("FAIL b2b_len: got %0d expected 4", n);
        end
        n_cmp++;
        if (MdDone !== 1'b1) begin
            n_err++; $display("FAIL b2b_done: got %b expected 1", MdDone);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int n;
        int done_seen;
        clear_inputs();
        MdStart_E = 2'b10;
        tick();
        MdStart_E = 2'b00;
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({MdBusy, MdDone} !== 2'b00) begin
            n_err++; $display("FAIL rst_async: got %b expected 00", {MdBusy, MdDone});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            if (MdDone !== 1'b0 || MdBusy !== 1'b0) done_seen++;
            tick();
        end
        n_cmp++;
        if (done_seen != 0) begin
            n_err++; $display("FAIL rst_no_done: got %0d active cycles expected 0", done_seen);
        end
        MdStart_E = 2'b01;
        tick();
        MdStart_E = 2'b00;
        run_length(-1, 2'b00, n);
        n_cmp++;
        if (n != 4) begin
            n_err++; $display("FAIL rst_restart_len: got %0d expected 4", n);
        end
        n_cmp++;
        if (MdDone !== 1'b1) begin
            n_err++; $display("FAIL rst_restart_done: got %b expected 1", MdDone);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_forwarding();
        test_zero_reg();
        test_branch();
        test_divide();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
